// File: rtl/tour_move_buf_if.sv
// Bundle between the move recorder and its neighbours.
// Port summary:
//   clr_tour, wr_mv, pop_mv, mv_in, tour_done : recording controls from TourLogic
//   mv_indx                                   : playback read address from TourCmd
//   move, start_tour, mv_cnt, err             : recorder outputs
//   state_dbg                                 : recorder FSM state, for observation
// Control semantics: clr_tour, wr_mv, pop_mv and tour_done are single-cycle
// strobes sampled on every rising clock edge. There is no back-pressure; the
// recorder accepts every strobe it sees. mv_indx -> move is a combinational read.
interface tour_move_buf_if #(
  parameter int IDX_W = 5,
  parameter int MV_W  = 8
);
  logic             clr_tour;
  logic             wr_mv;
  logic             pop_mv;
  logic [MV_W-1:0]  mv_in;
  logic             tour_done;
  logic [IDX_W-1:0] mv_indx;
  logic [MV_W-1:0]  move;
  logic             start_tour;
  logic [IDX_W-1:0] mv_cnt;
  logic             err;
  logic [1:0]       state_dbg;

  modport master (
    output clr_tour, wr_mv, pop_mv, mv_in, tour_done, mv_indx,
    input  move, start_tour, mv_cnt, err, state_dbg
  );

  modport slave (
    input  clr_tour, wr_mv, pop_mv, mv_in, tour_done, mv_indx,
    output move, start_tour, mv_cnt, err, state_dbg
  );
endinterface

// File: rtl/tour_move_buf.sv
// Move recorder between TourLogic and TourCmd.
// Records the one-hot knight moves TourLogic commits (wr_mv) and undoes
// (pop_mv), pulses start_tour once a full tour is held and tour_done is seen,
// then serves move[mv_indx] to TourCmd for playback.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, highest priority
//   bus  : tour_move_buf_if slave modport (controls in, move/start/count/err out)
module tour_move_buf #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5,
  parameter int MV_W      = 8
) (
  input logic            clk,
  input logic            rst,
  tour_move_buf_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    READY  = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] FULL = IDX_W'(NUM_MOVES);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [MV_W-1:0]  mem_q [NUM_MOVES];
  logic [MV_W-1:0]  mem_d [NUM_MOVES];
  logic             err_q, err_d;
  logic             start_q, start_d;

  logic             one_hot;
  logic             fault;
  logic [IDX_W-1:0] post_cnt;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign one_hot = (bus.mv_in != '0) && ((bus.mv_in & (bus.mv_in - 1'b1)) == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    err_d    = err_q;
    start_d  = 1'b0;
    fault    = 1'b0;
    post_cnt = cnt_q;

    if (bus.clr_tour) begin
      state_d = RECORD;
      cnt_d   = '0;
      err_d   = 1'b0;
      for (int i = 0; i < NUM_MOVES; i++) mem_d[i] = '0;
    end else begin
      case (state_q)
        RECORD: begin
          if (bus.wr_mv && bus.pop_mv) begin
            // Replace the top entry in place; count does not move.
            if (cnt_q == '0 || !one_hot) fault = 1'b1;
            else mem_d[cnt_q - 1'b1] = bus.mv_in;
          end else if (bus.wr_mv) begin
            if (!one_hot || cnt_q == FULL) fault = 1'b1;
            else begin
              mem_d[cnt_q] = bus.mv_in;
              post_cnt     = cnt_q + 1'b1;
            end
          end else if (bus.pop_mv) begin
            if (cnt_q == '0) fault = 1'b1;
            else begin
              mem_d[cnt_q - 1'b1] = '0;
              post_cnt            = cnt_q - 1'b1;
            end
          end

          // tour_done sees the count as it will be after this cycle's edit.
          if (bus.tour_done && !fault) begin
            if (post_cnt == FULL) begin
              state_d = READY;
              start_d = 1'b1;
            end else begin
              fault = 1'b1;
            end
          end

          if (fault) begin
            state_d = ERR;
            err_d   = 1'b1;
            mem_d   = mem_q;
          end else begin
            cnt_d = post_cnt;
          end
        end
        default: ; // IDLE, READY, ERR hold until clr_tour or rst
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      for (int i = 0; i < NUM_MOVES; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      start_q <= start_d;
      for (int i = 0; i < NUM_MOVES; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Entries at or above the live count read as zero.
  assign bus.move       = (bus.mv_indx < cnt_q) ? mem_q[bus.mv_indx] : '0;
  assign bus.start_tour = start_q;
  assign bus.mv_cnt     = cnt_q;
  assign bus.err        = err_q;
  assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_tour_move_buf.sv
// Self-checking bench for tour_move_buf: directed stimulus, expected-value
// queue, negedge monitor, one summary line.
module tb_tour_move_buf;
  localparam int W = 17; // {state, start_tour, err, mv_cnt[4:0], move[7:0]}
  localparam logic [1:0] S_IDLE = 2'd0, S_REC = 2'd1, S_READY = 2'd2, S_ERR = 2'd3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  tour_move_buf_if #(.IDX_W(5), .MV_W(8)) bus ();

  tour_move_buf #(.NUM_MOVES(24), .IDX_W(5), .MV_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- helpers / driver ----------------
  function automatic logic [W-1:0] pk(input logic [1:0] st, input logic s,
                                      input logic e, input logic [4:0] c,
                                      input logic [7:0] m);
    return {st, s, e, c, m};
  endfunction

  // One clock of stimulus: strobes are held across one rising edge, then
  // dropped and mv_indx set; the expected observation is queued for the
  // following negedge.
  task automatic tick(input logic r, input logic clr, input logic wr,
                      input logic pop, input logic done, input logic [7:0] mvin,
                      input logic [4:0] idx, input logic [W-1:0] exp,
                      input string nm);
    rst           = r;
    bus.clr_tour  = clr;
    bus.wr_mv     = wr;
    bus.pop_mv    = pop;
    bus.tour_done = done;
    bus.mv_in     = mvin;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.clr_tour  = 1'b0;
    bus.wr_mv     = 1'b0;
    bus.pop_mv    = 1'b0;
    bus.tour_done = 1'b0;
    bus.mv_in     = 8'h00;
    bus.mv_indx   = idx;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      logic [W-1:0] got;
      string        nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {bus.state_dbg, bus.start_tour, bus.err, bus.mv_cnt, bus.move};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL %s: got st=%0d start=%0b err=%0b cnt=%0d move=%h, expected st=%0d start=%0b err=%0b cnt=%0d move=%h",
                 nm, got[16:15], got[14], got[13], got[12:8], got[7:0],
                 e[16:15], e[14], e[13], e[12:8], e[7:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] mv;
    checks        = 0;
    failures      = 0;
    rst           = 1'b0;
    bus.clr_tour  = 1'b0;
    bus.wr_mv     = 1'b0;
    bus.pop_mv    = 1'b0;
    bus.tour_done = 1'b0;
    bus.mv_in     = 8'h00;
    bus.mv_indx   = 5'd0;
    #1;

    // 1. full tour
    tick(1, 0, 0, 0, 0, 8'h00, 5'd0, pk(S_IDLE, 0, 0, 5'd0, 8'h00), "reset");
    tick(0, 0, 1, 0, 0, 8'h01, 5'd0, pk(S_IDLE, 0, 0, 5'd0, 8'h00), "idle_wr_ignored");
    tick(0, 1, 0, 0, 0, 8'h00, 5'd0, pk(S_REC, 0, 0, 5'd0, 8'h00), "clr");
    for (int i = 0; i < 24; i++) begin
      mv = 8'h01 << (i % 8);
      tick(0, 0, 1, 0, 0, mv, 5'(i), pk(S_REC, 0, 0, 5'(i + 1), mv), "wr_full");
    end
    tick(0, 0, 0, 0, 1, 8'h00, 5'd0,  pk(S_READY, 1, 0, 5'd24, 8'h01), "done_start");
    tick(0, 0, 0, 0, 0, 8'h00, 5'd23, pk(S_READY, 0, 0, 5'd24, 8'h80), "start_one_cycle");
    tick(0, 0, 1, 1, 1, 8'h01, 5'd23, pk(S_READY, 0, 0, 5'd24, 8'h80), "ready_frozen");
    tick(0, 0, 0, 0, 0, 8'h00, 5'd24, pk(S_READY, 0, 0, 5'd24, 8'h00), "idx_past_cnt");

    // 2. non-one-hot write
    tick(0, 1, 0, 0, 0, 8'h00, 5'd0, pk(S_REC, 0, 0, 5'd0, 8'h00), "clr2");
    tick(0, 0, 1, 0, 0, 8'h03, 5'd0, pk(S_ERR, 0, 1, 5'd0, 8'h00), "bad_onehot");
    tick(0, 0, 0, 0, 1, 8'h00, 5'd0, pk(S_ERR, 0, 1, 5'd0, 8'h00), "err_done_no_start");
    tick(0, 0, 1, 0, 0, 8'h01, 5'd0, pk(S_ERR, 0, 1, 5'd0, 8'h00), "err_wr_ignored");
    tick(0, 1, 0, 0, 0, 8'h00, 5'd0, pk(S_REC, 0, 0, 5'd0, 8'h00), "clr_clears_err");
    tick(0, 0, 1, 0, 0, 8'h00, 5'd0, pk(S_ERR, 0, 1, 5'd0, 8'h00), "zero_mv_err");

    // 3. write / pop / write
    tick(0, 1, 0, 0, 0, 8'h00, 5'd0, pk(S_REC, 0, 0, 5'd0, 8'h00), "clr3");
    tick(0, 0, 1, 0, 0, 8'h01, 5'd0, pk(S_REC, 0, 0, 5'd1, 8'h01), "wr_a");
    tick(0, 0, 1, 0, 0, 8'h02, 5'd1, pk(S_REC, 0, 0, 5'd2, 8'h02), "wr_b");
    tick(0, 0, 1, 0, 0, 8'h04, 5'd2, pk(S_REC, 0, 0, 5'd3, 8'h04), "wr_c");
    tick(0, 0, 0, 1, 0, 8'h00, 5'd2, pk(S_REC, 0, 0, 5'd2, 8'h00), "pop");
    tick(0, 0, 1, 0, 0, 8'h40, 5'd2, pk(S_REC, 0, 0, 5'd3, 8'h40), "wr_after_pop");
    tick(0, 0, 0, 0, 0, 8'h00, 5'd3, pk(S_REC, 0, 0, 5'd3, 8'h00), "read_past_cnt");

    // 4. replace top, pop down to underflow
    tick(0, 0, 1, 0, 0, 8'h08, 5'd3, pk(S_REC, 0, 0, 5'd4, 8'h08), "wr_d");
    tick(0, 0, 1, 0, 0, 8'h20, 5'd4, pk(S_REC, 0, 0, 5'd5, 8'h20), "wr_e");
    tick(0, 0, 1, 1, 0, 8'h10, 5'd4, pk(S_REC, 0, 0, 5'd5, 8'h10), "replace_top");
    tick(0, 0, 0, 0, 0, 8'h00, 5'd3, pk(S_REC, 0, 0, 5'd5, 8'h08), "replace_keeps_below");
    for (int k = 4; k >= 1; k--)
      tick(0, 0, 0, 1, 0, 8'h00, 5'd0, pk(S_REC, 0, 0, 5'(k), 8'h01), "pop_down");
    tick(0, 0, 0, 1, 0, 8'h00, 5'd0, pk(S_REC, 0, 0, 5'd0, 8'h00), "pop_to_zero");
    tick(0, 0, 0, 1, 0, 8'h00, 5'd0, pk(S_ERR, 0, 1, 5'd0, 8'h00), "underflow");
    tick(0, 1, 0, 0, 0, 8'h00, 5'd0, pk(S_REC, 0, 0, 5'd0, 8'h00), "clr4");
    tick(0, 0, 1, 1, 0, 8'h10, 5'd0, pk(S_ERR, 0, 1, 5'd0, 8'h00), "replace_empty");

    // 5. early tour_done and overflow
    tick(0, 1, 0, 0, 0, 8'h00, 5'd0, pk(S_REC, 0, 0, 5'd0, 8'h00), "clr5");
    for (int i = 0; i < 23; i++) begin
      mv = 8'h01 << (i % 8);
      tick(0, 0, 1, 0, 0, mv, 5'(i), pk(S_REC, 0, 0, 5'(i + 1), mv), "wr_23");
    end
    tick(0, 0, 0, 0, 1, 8'h00, 5'd0, pk(S_ERR, 0, 1, 5'd23, 8'h01), "done_at_23");
    tick(0, 0, 0, 0, 0, 8'h00, 5'd0, pk(S_ERR, 0, 1, 5'd23, 8'h01), "no_start_in_err");
    tick(0, 1, 0, 0, 0, 8'h00, 5'd0, pk(S_REC, 0, 0, 5'd0, 8'h00), "clr6");
    for (int i = 0; i < 24; i++) begin
      mv = 8'h01 << (i % 8);
      tick(0, 0, 1, 0, 0, mv, 5'(i), pk(S_REC, 0, 0, 5'(i + 1), mv), "wr_24");
    end
    tick(0, 0, 1, 0, 0, 8'h01, 5'd23, pk(S_ERR, 0, 1, 5'd24, 8'h80), "overflow");

    // 6. reset mid-record
    tick(0, 1, 0, 0, 0, 8'h00, 5'd0, pk(S_REC, 0, 0, 5'd0, 8'h00), "clr7");
    for (int i = 0; i < 10; i++)
      tick(0, 0, 1, 0, 0, 8'h04, 5'(i), pk(S_REC, 0, 0, 5'(i + 1), 8'h04), "wr_10");
    tick(1, 0, 1, 0, 0, 8'h04, 5'd0, pk(S_IDLE, 0, 0, 5'd0, 8'h00), "rst_mid_record");
    for (int i = 0; i < 10; i += 3)
      tick(0, 0, 0, 0, 0, 8'h00, 5'(i), pk(S_IDLE, 0, 0, 5'd0, 8'h00), "rst_reads_zero");
    tick(0, 0, 1, 0, 0, 8'h02, 5'd0, pk(S_IDLE, 0, 0, 5'd0, 8'h00), "idle_after_rst");
    tick(1, 1, 0, 0, 0, 8'h00, 5'd0, pk(S_IDLE, 0, 0, 5'd0, 8'h00), "rst_over_clr");

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
